// File: rtl/mem_array.sv
// Single-port synchronous RAM with a registered, write-first read port.
// Reset clears only the output register; stored contents survive it.
module mem_array #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  write_en,
   output logic [DATA_WIDTH-1:0] data_out
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   // Power-up contents are zero (declaration initialiser maps to RAM init on FPGA).
   logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

   logic                  mem_we;
   logic [DATA_WIDTH-1:0] data_out_d, data_out_q;

   always_comb begin
      mem_we     = 1'b0;
      data_out_d = '0;
      if (!rst) begin
         if (write_en) begin
            mem_we     = 1'b1;
            data_out_d = data_in;
         end else begin
            data_out_d = mem_q[address];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[address] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      data_out_q <= data_out_d;
   end

   assign data_out = data_out_q;

endmodule

// File: tb/tb_mem_array.sv
// Scoreboard bench for mem_array: directed scenarios followed by random traffic,
// checked against an array-based reference model.
module tb_mem_array;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 8;
   localparam int unsigned NumRandom = 3000;
   localparam int unsigned NumDirected = 17;

   logic          clk;
   logic          rst;
   logic [AW-1:0] address;
   logic [DW-1:0] data_in;
   logic          write_en;
   logic [DW-1:0] data_out;

   mem_array #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .address (address),
      .data_in (data_in),
      .write_en(write_en),
      .data_out(data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] ref_mem [1024];
   logic [DW-1:0] exp_q [$];
   string         tag_q [$];
   int            vectors    = 0;
   int            miscompares = 0;

   // Apply one operation for the next rising edge and queue its expected output.
   task automatic op(input string tag, input bit r, input bit we, input int a, input int d);
      logic [DW-1:0] exp;
      @(negedge clk);
      rst      = r;
      write_en = we;
      address  = AW'(a);
      data_in  = DW'(d);
      if (r) begin
         exp = '0;
      end else if (we) begin
         ref_mem[a] = DW'(d);
         exp        = DW'(d);
      end else begin
         exp = ref_mem[a];
      end
      exp_q.push_back(exp);
      tag_q.push_back(tag);
   endtask

   // Monitor: every edge that had a queued operation yields one comparison.
   initial begin
      logic [DW-1:0] exp;
      string         tag;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            vectors++;
            if (data_out !== exp) begin
               miscompares++;
               $display("FAIL %s: data_out=%h expected=%h at %0t", tag, data_out, exp, $time);
            end
         end
      end
   end

   // Watchdog: the run must finish well before this wait expires.
   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, %0d vectors applied", vectors);
      $finish;
   end

   initial begin
      int a, d, sel;
      bit r, we;
      int pool [4];
      pool = '{0, 1023, 10, 511};
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      rst      = 1'b1;
      write_en = 1'b0;
      address  = '0;
      data_in  = '0;

      op("reset", 1, 0, 0, 0);
      @(posedge clk);
      #2;
      if (data_out !== '0) begin
         miscompares++;
         $display("FAIL reset state: data_out=%h expected=00 at %0t", data_out, $time);
      end

      op("t4_unwritten_500", 0, 0, 500, 0);
      op("t1_write_aa_0", 0, 1, 0, 'hAA);
      op("t1_read_0", 0, 0, 0, 0);
      op("t2_write_55_10", 0, 1, 10, 'h55);
      op("t2_read_10", 0, 0, 10, 0);
      op("t2_read_0", 0, 0, 0, 0);
      op("t3_write_ff_1023", 0, 1, 1023, 'hFF);
      op("t3_read_1023", 0, 0, 1023, 0);
      op("t3_read_0", 0, 0, 0, 0);
      op("t3_read_10", 0, 0, 10, 0);
      op("t5_reset_write", 1, 1, 10, 'h12);
      op("t5_read_10", 0, 0, 10, 0);
      op("t6_write_3c", 0, 1, 10, 'h3C);
      op("t6_write_c3", 0, 1, 10, 'hC3);
      op("t6_read_10", 0, 0, 10, 0);
      op("t4_unwritten_777", 0, 0, 777, 0);

      for (int i = 0; i < NumRandom; i++) begin
         sel = int'($urandom_range(0, 3));
         a   = (sel == 0) ? pool[$urandom_range(0, 3)] : int'($urandom_range(0, 1023));
         d   = int'($urandom_range(0, 255));
         r   = ($urandom_range(0, 19) == 0);
         we  = ($urandom_range(0, 1) == 1);
         op("random", r, we, a, d);
      end

      @(negedge clk);
      write_en = 1'b0;
      rst      = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      if (miscompares != 0 || vectors != int'(NumDirected + NumRandom)) begin
         $display("FAIL summary: %0d miscompares, %0d of %0d vectors checked",
                  miscompares, vectors, NumDirected + NumRandom);
      end else begin
         $display("PASS");
      end
      $finish;
   end

endmodule
